iencoder: RTL and testbench
===========================

// Module: iencoder
// PURPOSE
// - Inverse of the instruction decoder: packs decoded fields (type, rd, rs1, rs2, funct, imm)
//   into a 32-bit RV32I instruction word. Used by the self-test/program-loader path to build
//   instruction streams for instruction memory.
// - Valid/ready on both sides; output FIFO; illegal field combinations are dropped and reported.
// PARAMETERS
// - DEPTH  2  output FIFO entries (>=1); in_ready depends only on internal state
// - CNT_W  16 width of inst_count / err_count
// PORTS
// - clk         in   1                  clock, all logic on rising edge
// - rst         in   1                  synchronous reset, active-high
// - in_valid    in   1                  field bundle valid
// - in_ready    out  1                  encoder can accept a bundle
// - in_type     in   `INST_TYPE_WIDTH   `INST_TYPE_IMM / _INT_IMM / _INT_REG / _BRANCH
// - in_rd       in   `REG_WIDTH         destination register
// - in_rs1      in   `REG_WIDTH         source register 1
// - in_rs2      in   `REG_WIDTH         source register 2
// - in_funct    in   `FUNCT_WIDTH       {alt, funct3}; alt=1 selects SUB/SRA/SRAI
// - in_imm      in   `IMM_WIDTH         immediate, full sign-extended value
// - out_valid   out  1                  out_inst valid
// - out_ready   in   1                  consumer accepts out_inst
// - out_inst    out  `INST_WIDTH        encoded instruction (FIFO head)
// - err_valid   out  1                  one-cycle pulse: last accepted bundle was rejected
// - err_code    out  2                  1=imm unencodable, 2=bad funct, 3=unknown type
// - inst_count  out  CNT_W              words pushed into FIFO since reset, wraps
// - err_count   out  CNT_W              rejected bundles since reset, wraps
// BEHAVIOUR
// - Reset: FIFO empty, out_valid=0, out_inst=0, err_valid=0, err_code=0, counters=0.
// - Accept when in_valid && in_ready. in_ready = (fill < DEPTH); a same-cycle pop does NOT
//   raise in_ready (no out_ready->in_ready combinational path).
// - Accepted bundle encoded combinationally, pushed at that edge; out_valid high next cycle
//   (latency 1 when empty). Pop when out_valid && out_ready. Push+pop same cycle: fill unchanged.
// - FIFO order strict; out_inst holds stable while out_valid && !out_ready.
// - Encodings (rd at [11:7], funct3 [14:12], rs1 [19:15], rs2 [24:20]):
//   IMM (LUI, 0x37): {imm[31:12], rd, opc}; err 1 if imm[11:0]!=0.
//   INT_IMM (0x13): {imm[11:0], rs1, f3, rd, opc}; err 1 if imm[31:11] not all equal.
//     f3=1: err 1 if imm>31; alt must be 0 else err 2. f3=5: err 1 if imm>31;
//     [31:25]={1'b0,alt,5'b0}. Other f3: alt=1 -> err 2.
//   INT_REG (0x33): [31:25]={1'b0,alt,5'b0}; alt=1 legal only for f3=0/5, else err 2.
//   BRANCH (0x63): {imm[12],imm[10:5],rs2,rs1,f3,imm[4:1],imm[11],opc}; err 1 if imm[0]!=0 or
//     imm[31:12] != {20{imm[12]}}; err 2 if alt=1 or f3=2/3.
//   Any other type: err 3. Priority when several apply: 3 > 2 > 1.
// - Rejected bundle: consumed (handshake completes), not pushed; err_valid=1 and err_code set
//   the following cycle for exactly one cycle; err_count+1. Legal push: inst_count+1.
// - err_code holds last value when err_valid=0; cleared only by reset.
// - rst mid-operation: FIFO contents discarded, all state to reset values next cycle.
// TESTING
// - LUI rd=5 imm=0x12345000, out_ready=1 -> out_inst=0x123452B7 one cycle after accept.
// - INT_IMM f3=0 rd=1 rs1=2 imm=0xFFFFFFFF -> 0xFFF10093; imm=0x00000800 -> err_code=1, no word.
// - INT_REG alt=1 f3=0 rd=3 rs1=1 rs2=2 -> 0x402081B3; alt=1 f3=4 -> err_code=2, err_count=1.
// - BRANCH f3=0 rs1=1 rs2=2 imm=8 -> 0x00208463; imm=3 -> err_code=1; type=unknown -> err_code=3.
// - out_ready=0, push DEPTH legal words -> in_ready=0; raise out_ready -> words in order, in_ready
//   returns the cycle after first pop; inst_count=DEPTH.
// - Fill FIFO, assert rst one cycle -> out_valid=0, counters=0, in_ready=1 next cycle.

Source files
------------

// File: rtl/iencoder.sv
// RV32I instruction encoder: packs decoded fields into a 32-bit word behind a small
// output FIFO; bundles with illegal field combinations are consumed, dropped and reported.
`ifndef INST_TYPE_WIDTH
`define INST_TYPE_WIDTH 3
`endif
`ifndef REG_WIDTH
`define REG_WIDTH 5
`endif
`ifndef FUNCT_WIDTH
`define FUNCT_WIDTH 4
`endif
`ifndef IMM_WIDTH
`define IMM_WIDTH 32
`endif
`ifndef INST_WIDTH
`define INST_WIDTH 32
`endif
`ifndef INST_TYPE_IMM
`define INST_TYPE_IMM     3'd0
`define INST_TYPE_INT_IMM 3'd1
`define INST_TYPE_INT_REG 3'd2
`define INST_TYPE_BRANCH  3'd3
`endif

module iencoder #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [`INST_TYPE_WIDTH-1:0]  in_type,
  input  logic [`REG_WIDTH-1:0]        in_rd,
  input  logic [`REG_WIDTH-1:0]        in_rs1,
  input  logic [`REG_WIDTH-1:0]        in_rs2,
  input  logic [`FUNCT_WIDTH-1:0]      in_funct,
  input  logic [`IMM_WIDTH-1:0]        in_imm,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [`INST_WIDTH-1:0]       out_inst,
  output logic                         err_valid,
  output logic [1:0]                   err_code,
  output logic [CNT_W-1:0]             inst_count,
  output logic [CNT_W-1:0]             err_count
);

  localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned FILL_W = $clog2(DEPTH + 1);

  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_BRANCH = 7'h63;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_IMM  = 2'd1;
  localparam logic [1:0] ERR_FN   = 2'd2;
  localparam logic [1:0] ERR_TYPE = 2'd3;

  logic [`INST_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [FILL_W-1:0]      fill;

  logic [`INST_WIDTH-1:0] enc_inst;
  logic [1:0]             enc_err;
  logic                   alt;
  logic [2:0]             f3;
  logic                   imm12_ok;
  logic                   shamt_ok;
  logic                   br_hi_ok;
  logic                   fire;
  logic                   push;
  logic                   pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign in_ready  = (fill < FILL_W'(DEPTH));
  assign out_valid = (fill != '0);
  assign out_inst  = mem[rd_ptr];

  assign fire = in_valid && in_ready;
  assign push = fire && (enc_err == ERR_NONE);
  assign pop  = out_valid && out_ready;

  assign alt      = in_funct[3];
  assign f3       = in_funct[2:0];
  assign imm12_ok = (&in_imm[31:11]) || !(|in_imm[31:11]);
  assign shamt_ok = !(|in_imm[31:5]);
  assign br_hi_ok = (in_imm[31:12] == {20{in_imm[12]}});

  // Field packing and legality; funct errors are checked before immediate errors
  always_comb begin
    enc_inst = '0;
    enc_err  = ERR_NONE;
    case (in_type)
      `INST_TYPE_IMM: begin
        enc_inst = {in_imm[31:12], in_rd, OPC_LUI};
        if (in_imm[11:0] != 12'd0) enc_err = ERR_IMM;
      end
      `INST_TYPE_INT_IMM: begin
        enc_inst = {in_imm[11:0], in_rs1, f3, in_rd, OPC_OP_IMM};
        if (f3 == 3'd1) begin
          if (alt)            enc_err = ERR_FN;
          else if (!shamt_ok) enc_err = ERR_IMM;
        end else if (f3 == 3'd5) begin
          enc_inst[31:25] = {1'b0, alt, 5'b0};
          if (!shamt_ok) enc_err = ERR_IMM;
        end else begin
          if (alt)            enc_err = ERR_FN;
          else if (!imm12_ok) enc_err = ERR_IMM;
        end
      end
      `INST_TYPE_INT_REG: begin
        enc_inst = {1'b0, alt, 5'b0, in_rs2, in_rs1, f3, in_rd, OPC_OP};
        if (alt && (f3 != 3'd0) && (f3 != 3'd5)) enc_err = ERR_FN;
      end
      `INST_TYPE_BRANCH: begin
        enc_inst = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, f3,
                    in_imm[4:1], in_imm[11], OPC_BRANCH};
        if (alt || (f3 == 3'd2) || (f3 == 3'd3)) enc_err = ERR_FN;
        else if (in_imm[0] || !br_hi_ok)         enc_err = ERR_IMM;
      end
      default: enc_err = ERR_TYPE;
    endcase
  end

  // Output FIFO storage and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= enc_inst;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   fill <= fill + FILL_W'(1);
        2'b01:   fill <= fill - FILL_W'(1);
        default: fill <= fill;
      endcase
    end
  end

  // Error reporting and statistics
  always_ff @(posedge clk) begin
    if (rst) begin
      err_valid  <= 1'b0;
      err_code   <= ERR_NONE;
      inst_count <= '0;
      err_count  <= '0;
    end else begin
      err_valid <= fire && (enc_err != ERR_NONE);
      if (fire && (enc_err != ERR_NONE)) begin
        err_code  <= enc_err;
        err_count <= err_count + CNT_W'(1);
      end
      if (push) inst_count <= inst_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_iencoder.sv
// Scoreboarded bench for iencoder: directed field bundles with hand-encoded expected words.
module tb_iencoder;

  localparam int unsigned DEPTH = 2;
  localparam int unsigned CNT_W = 16;

  localparam logic [2:0] T_IMM  = 3'd0;
  localparam logic [2:0] T_IIMM = 3'd1;
  localparam logic [2:0] T_IREG = 3'd2;
  localparam logic [2:0] T_BR   = 3'd3;
  localparam logic [2:0] T_BAD  = 3'd4;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_type;
  logic [4:0]       in_rd;
  logic [4:0]       in_rs1;
  logic [4:0]       in_rs2;
  logic [3:0]       in_funct;
  logic [31:0]      in_imm;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_inst;
  logic             err_valid;
  logic [1:0]       err_code;
  logic [CNT_W-1:0] inst_count;
  logic [CNT_W-1:0] err_count;

  int checks = 0;
  int errors = 0;
  int n_inst = 0;
  int n_err  = 0;
  logic [31:0] exp_q [$];
  logic [1:0]  err_q [$];
  logic [31:0] mon_word;
  logic [1:0]  mon_err;

  iencoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_type(in_type), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct(in_funct), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
    .err_valid(err_valid), .err_code(err_code),
    .inst_count(inst_count), .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: compares every popped word and every error pulse against the scoreboard
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_word: got 0x%08h with empty scoreboard", out_inst);
      end else begin
        mon_word = exp_q.pop_front();
        check("out_inst", out_inst, mon_word);
      end
    end
    if (!rst && err_valid) begin
      if (err_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_err: got code %0d with empty scoreboard", err_code);
      end else begin
        mon_err = err_q.pop_front();
        check("err_code", 32'(err_code), 32'(mon_err));
      end
    end
  end

  // Drive one bundle until accepted; returns 1 time unit after the accepting edge
  task automatic send(input logic [2:0] t, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [3:0] fn, input logic [31:0] imm,
                      input logic [1:0] eerr, input logic [31:0] einst);
    int k;
    in_type = t; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_funct = fn; in_imm = imm;
    in_valid = 1'b1;
    k = 0;
    @(negedge clk);
    while (!in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles", k);
    end
    if (eerr == 2'd0) begin
      exp_q.push_back(einst);
      n_inst++;
    end else begin
      err_q.push_back(eerr);
      n_err++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((exp_q.size() != 0 || err_q.size() != 0) && k < 100) begin
      @(posedge clk);
      k++;
    end
    #1;
    if (exp_q.size() != 0 || err_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: %0d words %0d errors outstanding", exp_q.size(), err_q.size());
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_type = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_funct = '0; in_imm = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_inst", out_inst, 32'd0);
    check("rst_err_valid", 32'(err_valid), 32'd0);
    check("rst_err_code", 32'(err_code), 32'd0);
    check("rst_inst_count", 32'(inst_count), 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // Fill with consumer stalled, then release it
    @(posedge clk); #1;
    send(T_IMM,  5'd5, 5'd0, 5'd0, 4'h0, 32'h12345000, 2'd0, 32'h123452B7);
    send(T_IREG, 5'd3, 5'd1, 5'd2, 4'h8, 32'h0,        2'd0, 32'h402081B3);
    check("full_in_ready", 32'(in_ready), 32'd0);
    check("full_out_valid", 32'(out_valid), 32'd1);
    check("full_inst_count", 32'(inst_count), 32'(n_inst));
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("pop_cycle_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    check("after_pop_in_ready", 32'(in_ready), 32'd1);
    drain();

    // Latency with consumer ready
    send(T_IMM, 5'd5, 5'd0, 5'd0, 4'h0, 32'h12345000, 2'd0, 32'h123452B7);
    check("latency_out_valid", 32'(out_valid), 32'd1);
    send(T_IIMM, 5'd1, 5'd2, 5'd0, 4'h0, 32'hFFFFFFFF, 2'd0, 32'hFFF10093);
    send(T_IIMM, 5'd1, 5'd2, 5'd0, 4'h0, 32'h00000800, 2'd1, 32'h0);
    check("imm_err_out_valid", 32'(out_valid), 32'd0);
    check("imm_err_valid", 32'(err_valid), 32'd1);
    send(T_IIMM, 5'd1, 5'd2, 5'd0, 4'h0, 32'hFFFFF800, 2'd0, 32'h80010093);
    send(T_IIMM, 5'd1, 5'd2, 5'd0, 4'h1, 32'd31,       2'd0, 32'h01F11093);
    send(T_IIMM, 5'd1, 5'd2, 5'd0, 4'h1, 32'd32,       2'd1, 32'h0);
    send(T_IIMM, 5'd1, 5'd2, 5'd0, 4'hD, 32'd3,        2'd0, 32'h40315093);
    send(T_IIMM, 5'd1, 5'd2, 5'd0, 4'h9, 32'd40,       2'd2, 32'h0);
    send(T_IREG, 5'd3, 5'd1, 5'd2, 4'hC, 32'h0,        2'd2, 32'h0);
    check("err_count_mid", 32'(err_count), 32'(n_err));
    send(T_BR,   5'd0, 5'd1, 5'd2, 4'h0, 32'd8,        2'd0, 32'h00208463);
    send(T_BR,   5'd0, 5'd1, 5'd2, 4'h1, 32'hFFFFFFFC, 2'd0, 32'hFE209EE3);
    send(T_BR,   5'd0, 5'd1, 5'd2, 4'h0, 32'd3,        2'd1, 32'h0);
    send(T_BR,   5'd0, 5'd1, 5'd2, 4'h0, 32'h00001000, 2'd1, 32'h0);
    send(T_BR,   5'd0, 5'd1, 5'd2, 4'h2, 32'd3,        2'd2, 32'h0);
    send(T_IMM,  5'd5, 5'd0, 5'd0, 4'h0, 32'h12345001, 2'd1, 32'h0);
    send(T_BAD,  5'd1, 5'd1, 5'd1, 4'hA, 32'd1,        2'd3, 32'h0);
    drain();
    repeat (3) @(posedge clk);
    #1;
    check("err_code_hold", 32'(err_code), 32'd3);
    check("err_valid_idle", 32'(err_valid), 32'd0);
    check("inst_count_end", 32'(inst_count), 32'(n_inst));
    check("err_count_end", 32'(err_count), 32'(n_err));

    // Reset while full
    out_ready = 1'b0;
    send(T_IMM, 5'd1, 5'd0, 5'd0, 4'h0, 32'h00001000, 2'd0, 32'h000010B7);
    send(T_IMM, 5'd2, 5'd0, 5'd0, 4'h0, 32'h00002000, 2'd0, 32'h00002137);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete(); err_q.delete();
    n_inst = 0; n_err = 0;
    @(negedge clk);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_inst_count", 32'(inst_count), 32'd0);
    check("mid_rst_err_count", 32'(err_count), 32'd0);
    check("mid_rst_err_code", 32'(err_code), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
